id_ex_shift_stage: RTL

//   ID/EX pipeline register for the shift datapath; sits directly upstream of the EX shift unit.

---
 rtl/id_ex_shift_stage.sv | 123 ++++++++++++
 1 files changed

// File: rtl/id_ex_shift_stage.sv
// ID/EX pipeline register for the shift datapath. Holds decoded shift operands
// and control, and forwards EX/MEM or MEM/WB results onto the rt/rs operands.
module id_ex_shift_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [DATA_W-1:0] id_rt_i,
  input  logic [DATA_W-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_addr_i,
  input  logic [REG_AW-1:0] id_rs_addr_i,
  input  logic [REG_AW-1:0] id_rd_addr_i,
  input  logic [4:0]        id_shamt_i,
  input  logic              id_var_shift_i,
  input  logic [1:0]        id_shift_type_i,
  input  logic              exm_wr_i,
  input  logic [REG_AW-1:0] exm_rd_i,
  input  logic [DATA_W-1:0] exm_data_i,
  input  logic              mwb_wr_i,
  input  logic [REG_AW-1:0] mwb_rd_i,
  input  logic [DATA_W-1:0] mwb_data_i,
  output logic              ex_valid_o,
  output logic [DATA_W-1:0] rt_o,
  output logic [DATA_W-1:0] rs_o,
  output logic [4:0]        shamt_o,
  output logic              var_shift_o,
  output logic [1:0]        shift_type_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic              ex_reg_write_o,
  output logic [1:0]        fwd_rt_o,
  output logic [1:0]        fwd_rs_o
);

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EXM = 2'b01;
  localparam logic [1:0] FWD_MWB = 2'b10;

  logic              valid_q;
  logic [DATA_W-1:0] rt_q;
  logic [DATA_W-1:0] rs_q;
  logic [REG_AW-1:0] rt_addr_q;
  logic [REG_AW-1:0] rs_addr_q;
  logic [REG_AW-1:0] rd_q;
  logic [4:0]        shamt_q;
  logic              var_shift_q;
  logic [1:0]        shift_type_q;

  logic exm_hit_rt, exm_hit_rs, mwb_hit_rt, mwb_hit_rs;

  // Register 0 is hard-wired zero, so it never matches a producer.
  assign exm_hit_rt = exm_wr_i && (exm_rd_i != '0) && (exm_rd_i == rt_addr_q);
  assign exm_hit_rs = exm_wr_i && (exm_rd_i != '0) && (exm_rd_i == rs_addr_q);
  assign mwb_hit_rt = mwb_wr_i && (mwb_rd_i != '0) && (mwb_rd_i == rt_addr_q);
  assign mwb_hit_rs = mwb_wr_i && (mwb_rd_i != '0) && (mwb_rd_i == rs_addr_q);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    fwd_rt_o = FWD_REG;
    fwd_rs_o = FWD_REG;
    if (valid_q) begin
      if (exm_hit_rt)      fwd_rt_o = FWD_EXM;
      else if (mwb_hit_rt) fwd_rt_o = FWD_MWB;
      if (exm_hit_rs)      fwd_rs_o = FWD_EXM;
      else if (mwb_hit_rs) fwd_rs_o = FWD_MWB;
    end
  end

  always_comb begin
    rt_o = rt_q;
    rs_o = rs_q;
    case (fwd_rt_o)
      FWD_EXM: rt_o = exm_data_i;
      FWD_MWB: rt_o = mwb_data_i;
      default: rt_o = rt_q;
    endcase
    case (fwd_rs_o)
      FWD_EXM: rs_o = exm_data_i;
      FWD_MWB: rs_o = mwb_data_i;
      default: rs_o = rs_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      valid_q      <= 1'b0;
      rt_q         <= '0;
      rs_q         <= '0;
      rt_addr_q    <= '0;
      rs_addr_q    <= '0;
      rd_q         <= '0;
      shamt_q      <= '0;
      var_shift_q  <= 1'b0;
      shift_type_q <= 2'b00;
    end else if (stall_i) begin
      // Capture any forwarded value now, since the producer may retire during the stall.
      rt_q <= rt_o;
      rs_q <= rs_o;
    end else begin
      valid_q      <= id_valid_i;
      rt_q         <= id_rt_i;
      rs_q         <= id_rs_i;
      rt_addr_q    <= id_rt_addr_i;
      rs_addr_q    <= id_rs_addr_i;
      rd_q         <= id_rd_addr_i;
      shamt_q      <= id_shamt_i;
      var_shift_q  <= id_var_shift_i;
      shift_type_q <= id_shift_type_i;
    end
  end

  assign ex_valid_o     = valid_q;
  assign shamt_o        = shamt_q;
  assign var_shift_o    = var_shift_q;
  assign shift_type_o   = shift_type_q;
  assign ex_rd_o        = rd_q;
  assign ex_reg_write_o = valid_q && (rd_q != '0);

endmodule
